// File: rtl/ravenoc_flit_injector.sv
// Transmit end of a router link: one packet command plus a payload stream become
// HEAD/BODY/TAIL flits on a per-VC valid/ready port, one registered flit per cycle.
`timescale 1ns/1ps
module ravenoc_flit_injector #(
    parameter int FLIT_WIDTH = 34,
    parameter int N_VIRT_CHN = 2,
    parameter int X_W        = 2,
    parameter int Y_W        = 2,
    parameter int MAX_SZ_PKT = 256,
    localparam int PKT_W     = $clog2(MAX_SZ_PKT),
    localparam int VC_W      = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1
) (
    input  logic                  clk_noc,
    input  logic                  arst_noc,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [VC_W-1:0]       cmd_vc,
    input  logic [X_W-1:0]        cmd_x,
    input  logic [Y_W-1:0]        cmd_y,
    input  logic [PKT_W-1:0]      cmd_len,
    input  logic                  pld_valid,
    output logic                  pld_ready,
    input  logic [FLIT_WIDTH-3:0] pld_data,
    output logic                  send_valid,
    output logic [VC_W-1:0]       send_vc_id,
    output logic [FLIT_WIDTH-1:0] send_fdata,
    input  logic [N_VIRT_CHN-1:0] send_ready,
    output logic                  busy,
    output logic [15:0]           pkt_sent,
    output logic [1:0]            dbg_state
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HEAD  = 2'd1;
    localparam logic [1:0] ST_BODY  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [1:0] TYPE_HEAD = 2'b00;
    localparam logic [1:0] TYPE_BODY = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    localparam int HEAD_PAD = FLIT_WIDTH - 2 - X_W - Y_W - PKT_W;

    logic [1:0]            state_q, state_d;
    logic                  send_valid_q, send_valid_d;
    logic [VC_W-1:0]       send_vc_q, send_vc_d;
    logic [FLIT_WIDTH-1:0] send_fdata_q, send_fdata_d;
    logic [PKT_W-1:0]      len_q, len_d;
    logic [PKT_W-1:0]      remain_q, remain_d;
    logic [15:0]           pkt_sent_q, pkt_sent_d;

    logic                  send_hs;
    logic [PKT_W-1:0]      beat_remain;
    logic                  beat_take;

    // Handshakes: a transfer happens on a rising clk_noc edge where valid and ready are both 1;
    // for flits the ready is send_ready[send_vc_id]. A raised valid holds its data until transfer.
    assign send_hs   = send_valid_q && send_ready[send_vc_q];
    assign beat_take = pld_valid && pld_ready;

    always_comb begin
        state_d      = state_q;
        send_valid_d = send_valid_q;
        send_vc_d    = send_vc_q;
        send_fdata_d = send_fdata_q;
        len_d        = len_q;
        remain_d     = remain_q;
        pkt_sent_d   = pkt_sent_q;
        beat_remain  = remain_q;
        cmd_ready    = (state_q == ST_IDLE);
        pld_ready    = 1'b0;

        if (send_hs) begin
            send_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    len_d        = cmd_len;
                    send_vc_d    = cmd_vc;
                    send_valid_d = 1'b1;
                    send_fdata_d = {TYPE_HEAD, cmd_x, cmd_y, cmd_len, {HEAD_PAD{1'b0}}};
                    state_d      = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (send_hs) begin
                    if (len_q == '0) begin
                        state_d    = ST_IDLE;
                        pkt_sent_d = pkt_sent_q + 16'd1;
                    end else begin
                        // The first beat may refill the register in the head's handoff cycle,
                        // so head and body leave back to back.
                        state_d     = ST_BODY;
                        remain_d    = len_q;
                        beat_remain = len_q;
                        pld_ready   = 1'b1;
                    end
                end
            end
            ST_BODY: begin
                pld_ready = !send_valid_q || send_hs;
            end
            ST_DRAIN: begin
                if (send_hs) begin
                    state_d    = ST_IDLE;
                    pkt_sent_d = pkt_sent_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (beat_take) begin
            send_valid_d = 1'b1;
            send_fdata_d = {(beat_remain == PKT_W'(1)) ? TYPE_TAIL : TYPE_BODY, pld_data};
            remain_d     = beat_remain - PKT_W'(1);
            if (beat_remain == PKT_W'(1)) begin
                state_d = ST_DRAIN;
            end
        end
    end

    always_ff @(posedge clk_noc) begin
        if (arst_noc) begin
            state_q      <= ST_IDLE;
            send_valid_q <= 1'b0;
            send_vc_q    <= '0;
            send_fdata_q <= '0;
            len_q        <= '0;
            remain_q     <= '0;
            pkt_sent_q   <= '0;
        end else begin
            state_q      <= state_d;
            send_valid_q <= send_valid_d;
            send_vc_q    <= send_vc_d;
            send_fdata_q <= send_fdata_d;
            len_q        <= len_d;
            remain_q     <= remain_d;
            pkt_sent_q   <= pkt_sent_d;
        end
    end

    assign send_valid = send_valid_q;
    assign send_vc_id = send_vc_q;
    assign send_fdata = send_fdata_q;
    assign busy       = (state_q != ST_IDLE) || send_valid_q;
    assign pkt_sent   = pkt_sent_q;
    assign dbg_state  = state_q;

    // A packet can never hold more than MAX_SZ_PKT flits including its head.
    assert property (@(posedge clk_noc) disable iff (arst_noc)
        (cmd_valid && cmd_ready) |-> (int'(cmd_len) <= MAX_SZ_PKT - 1));

endmodule

// File: tb/tb_ravenoc_flit_injector.sv
// Bench for ravenoc_flit_injector: queue-based packet model checked every cycle,
// directed scenarios with literal expectations, then randomized packets.
`timescale 1ns/1ps
module tb_ravenoc_flit_injector;
    localparam int FW    = 34;
    localparam int VC_W  = 1;
    localparam int PKT_W = 8;
    localparam int EW    = FW + VC_W + 1;

    logic            clk_noc;
    logic            arst_noc;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [VC_W-1:0] cmd_vc;
    logic [1:0]      cmd_x;
    logic [1:0]      cmd_y;
    logic [PKT_W-1:0] cmd_len;
    logic            pld_valid;
    logic            pld_ready;
    logic [FW-3:0]   pld_data;
    logic            send_valid;
    logic [VC_W-1:0] send_vc_id;
    logic [FW-1:0]   send_fdata;
    logic [1:0]      send_ready;
    logic            busy;
    logic [15:0]     pkt_sent;
    logic [1:0]      dbg_state;

    ravenoc_flit_injector dut (
        .clk_noc    (clk_noc),
        .arst_noc   (arst_noc),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_vc     (cmd_vc),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_len    (cmd_len),
        .pld_valid  (pld_valid),
        .pld_ready  (pld_ready),
        .pld_data   (pld_data),
        .send_valid (send_valid),
        .send_vc_id (send_vc_id),
        .send_fdata (send_fdata),
        .send_ready (send_ready),
        .busy       (busy),
        .pkt_sent   (pkt_sent),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_noc = 1'b0;
        forever #5 clk_noc = ~clk_noc;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- stimulus sources ----------------
    logic [FW-3:0] pld_src_q[$];
    bit            pld_take  = 1'b0;
    bit            gap_en    = 1'b0;
    int            rdy_mode  = 0;
    logic [1:0]    rdy_fixed = 2'b11;
    bit            tog       = 1'b0;

    always @(posedge clk_noc) begin
        bit took;
        #1;
        took     = pld_take;
        pld_take = 1'b0;
        if (took && pld_src_q.size() > 0) void'(pld_src_q.pop_front());
        if (!(pld_valid && !took && pld_src_q.size() > 0)) begin
            if (pld_src_q.size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                pld_valid = 1'b1;
                pld_data  = pld_src_q[0];
            end else begin
                pld_valid = 1'b0;
                pld_data  = $urandom;
            end
        end
        tog = ~tog;
        case (rdy_mode)
            0: send_ready = 2'b11;
            1: send_ready = 2'($urandom_range(0, 3));
            2: send_ready = tog ? 2'b11 : 2'b00;
            default: send_ready = rdy_fixed;
        endcase
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    // exp_q holds flits the injector owes the link, each {last_of_packet, vc, flit}.
    logic [EW-1:0]   exp_q[$];
    bit              m_active   = 1'b0;
    int              m_owed     = 0;
    logic [VC_W-1:0] m_vc       = '0;
    logic [15:0]     m_pkt_sent = '0;
    int              cyc        = 0;
    int              hs_cyc_q[$];
    logic [FW-1:0]   hs_dat_q[$];
    logic [VC_W-1:0] hs_vc_q[$];

    function automatic logic [FW-1:0] head_flit(input logic [1:0] x, input logic [1:0] y,
                                                input logic [PKT_W-1:0] len);
        return (FW'(x) << 30) | (FW'(y) << 28) | (FW'(len) << 20);
    endfunction

    always @(negedge clk_noc) begin
        logic [EW-1:0] front;
        bit exp_valid, hs_exp, pld_rdy_exp, was_active;
        cyc++;
        if (arst_noc) begin
            exp_q.delete();
            m_active   = 1'b0;
            m_owed     = 0;
            m_pkt_sent = '0;
        end else begin
            exp_valid   = exp_q.size() > 0;
            front       = exp_valid ? exp_q[0] : '0;
            hs_exp      = exp_valid && send_ready[front[FW +: VC_W]];
            was_active  = m_active;
            pld_rdy_exp = m_active && (m_owed != 0) && (!exp_valid || hs_exp);

            chk("send_valid", send_valid, exp_valid);
            if (exp_valid) begin
                chk("send_fdata", send_fdata, front[FW-1:0]);
                chk("send_vc_id", send_vc_id, front[FW +: VC_W]);
            end
            chk("cmd_ready", cmd_ready, !m_active);
            chk("pld_ready", pld_ready, pld_rdy_exp);
            chk("busy", busy, m_active);
            chk("pkt_sent", pkt_sent, m_pkt_sent);

            if (hs_exp) begin
                void'(exp_q.pop_front());
                hs_cyc_q.push_back(cyc);
                hs_dat_q.push_back(front[FW-1:0]);
                hs_vc_q.push_back(front[FW +: VC_W]);
                if (front[EW-1]) begin
                    m_active   = 1'b0;
                    m_pkt_sent = m_pkt_sent + 16'd1;
                end
            end
            if (pld_valid && pld_rdy_exp) begin
                m_owed--;
                exp_q.push_back({m_owed == 0, m_vc, (m_owed == 0) ? 2'b10 : 2'b01, pld_data});
                pld_take = 1'b1;
            end
            if (cmd_valid && !was_active) begin
                exp_q.push_back({cmd_len == 0, cmd_vc, head_flit(cmd_x, cmd_y, cmd_len)});
                m_active = 1'b1;
                m_owed   = int'(cmd_len);
                m_vc     = cmd_vc;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        hs_cyc_q.delete();
        hs_dat_q.delete();
        hs_vc_q.delete();
    endtask

    task automatic send_cmd(input logic [VC_W-1:0] vc, input logic [1:0] x, input logic [1:0] y,
                            input logic [PKT_W-1:0] len);
        bit ok;
        ok = 1'b0;
        @(posedge clk_noc); #1;
        cmd_valid = 1'b1;
        cmd_vc    = vc;
        cmd_x     = x;
        cmd_y     = y;
        cmd_len   = len;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_noc);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_noc); #1;
        cmd_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            $display("FAIL cmd_accept: cmd_ready never seen, expected within 3000 cycles");
        end
    endtask

    task automatic push_payload(input int n);
        for (int i = 0; i < n; i++) pld_src_q.push_back(FW'($urandom));
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk_noc); #1;
            if (!m_active && exp_q.size() == 0 && pld_src_q.size() == 0) return;
        end
        n_checks++;
        $display("FAIL %s: packet still in progress after 5000 cycles, expected idle", name);
    endtask

    // ---------------- scenarios ----------------
    logic [FW-1:0] exp3[4];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        arst_noc   = 1'b1;
        cmd_valid  = 1'b0;
        cmd_vc     = '0;
        cmd_x      = '0;
        cmd_y      = '0;
        cmd_len    = '0;
        pld_valid  = 1'b0;
        pld_data   = '0;
        send_ready = 2'b11;
        repeat (3) @(posedge clk_noc);
        #1 arst_noc = 1'b0;
        @(negedge clk_noc); #1;
        chk("rst_send_valid", send_valid, 1'b0);
        chk("rst_send_fdata", send_fdata, '0);
        chk("rst_send_vc_id", send_vc_id, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_pld_ready", pld_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pkt_sent", pkt_sent, 16'd0);

        // Head-only packet on VC 1 with only VC 1 ready.
        rdy_mode  = 3;
        rdy_fixed = 2'b10;
        clear_logs();
        send_cmd(1'b1, 2'd1, 2'd2, 8'd0);
        wait_idle("head_only");
        chk("ho_flit_count", hs_dat_q.size(), 1);
        if (hs_dat_q.size() == 1) begin
            chk("ho_flit", hs_dat_q[0], 34'h0_6000_0000);
            chk("ho_vc", hs_vc_q[0], 1'b1);
        end
        @(negedge clk_noc); #1;
        chk("ho_pkt_sent", pkt_sent, 16'd1);
        chk("ho_cmd_ready", cmd_ready, 1'b1);

        // Three body flits with ready always high: four flits on consecutive cycles.
        rdy_mode = 0;
        gap_en   = 1'b0;
        clear_logs();
        pld_src_q.push_back(32'h1111_1111);
        pld_src_q.push_back(32'h2222_2222);
        pld_src_q.push_back(32'h3333_3333);
        send_cmd(1'b0, 2'd2, 2'd1, 8'd3);
        wait_idle("three_body");
        exp3[0] = 34'h0_9030_0000;
        exp3[1] = 34'h1_1111_1111;
        exp3[2] = 34'h1_2222_2222;
        exp3[3] = 34'h2_3333_3333;
        chk("tb_flit_count", hs_dat_q.size(), 4);
        if (hs_dat_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("tb_flit%0d", i), hs_dat_q[i], exp3[i]);
                chk($sformatf("tb_cycle%0d", i), hs_cyc_q[i], hs_cyc_q[0] + i);
            end
        end

        // Backpressure: ready toggles every cycle.
        rdy_mode = 2;
        clear_logs();
        push_payload(5);
        send_cmd(1'b1, 2'd3, 2'd0, 8'd5);
        wait_idle("backpressure");
        chk("bp_flit_count", hs_dat_q.size(), 6);

        // Packet on VC 0 while only VC 1 is ready: the head must sit on the port.
        rdy_mode  = 3;
        rdy_fixed = 2'b10;
        clear_logs();
        push_payload(2);
        send_cmd(1'b0, 2'd3, 2'd3, 8'd2);
        repeat (5) @(negedge clk_noc);
        #1;
        chk("wv_send_valid", send_valid, 1'b1);
        chk("wv_head", send_fdata, 34'h0_F020_0000);
        chk("wv_no_handoff", hs_dat_q.size(), 0);
        chk("wv_state_head", dbg_state, 2'd1);
        chk("wv_pld_ready", pld_ready, 1'b0);
        chk("wv_busy", busy, 1'b1);
        rdy_mode = 0;
        wait_idle("wrong_vc_release");

        // Reset in the middle of a 5-body packet.
        rdy_mode = 0;
        clear_logs();
        push_payload(5);
        send_cmd(1'b1, 2'd0, 2'd1, 8'd5);
        for (int i = 0; i < 200 && hs_dat_q.size() < 2; i++) begin
            @(negedge clk_noc); #1;
        end
        chk("mr_progress", hs_dat_q.size() >= 2, 1'b1);
        @(posedge clk_noc); #1;
        arst_noc = 1'b1;
        pld_src_q.delete();
        @(posedge clk_noc); #1;
        arst_noc = 1'b0;
        @(negedge clk_noc); #1;
        chk("mr_send_valid", send_valid, 1'b0);
        chk("mr_busy", busy, 1'b0);
        chk("mr_cmd_ready", cmd_ready, 1'b1);
        chk("mr_pkt_sent", pkt_sent, 16'd0);
        clear_logs();
        push_payload(2);
        send_cmd(1'b0, 2'd1, 2'd1, 8'd2);
        wait_idle("after_reset");
        chk("mr_new_flits", hs_dat_q.size(), 3);

        // Randomized packets, ready patterns and payload gaps.
        for (int p = 0; p < 40; p++) begin
            int len;
            rdy_mode = $urandom_range(0, 2);
            gap_en   = $urandom_range(0, 1);
            len      = ($urandom_range(0, 3) == 0) ? $urandom_range(7, 40) : $urandom_range(0, 6);
            push_payload(len);
            send_cmd(VC_W'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), PKT_W'(len));
            wait_idle("random");
        end

        // Counter wrap: preload the count to its maximum, then one more head-only packet.
        rdy_mode = 0;
        gap_en   = 1'b0;
        @(posedge clk_noc); #2;
        force dut.pkt_sent_q = 16'hFFFF;
        m_pkt_sent = 16'hFFFF;
        @(posedge clk_noc); #2;
        release dut.pkt_sent_q;
        @(negedge clk_noc); #1;
        chk("wrap_preload", pkt_sent, 16'hFFFF);
        send_cmd(1'b0, 2'd0, 2'd0, 8'd0);
        wait_idle("wrap");
        @(negedge clk_noc); #1;
        chk("wrap_pkt_sent", pkt_sent, 16'd0);
        chk("wrap_cmd_ready", cmd_ready, 1'b1);

        repeat (3) @(posedge clk_noc);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
